// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA rectangle fill engine:
// framebuffer geometry, CSR offsets and the fill FSM state encoding.
package vga_fb_pkg;

    localparam int FB_WIDTH      = 640;
    localparam int FB_HEIGHT     = 480;
    localparam int WORDS_PER_ROW = 40;
    localparam int PX_PER_GROUP  = 4;
    localparam int GROUPS_PER_WD = 4;

    // First VRAM word of the palette region; fills must stay below it.
    localparam logic [14:0] PALETTE_BASE = 15'h4B00;

    // CSR word offsets
    localparam logic [2:0] CSR_X0    = 3'd0;
    localparam logic [2:0] CSR_Y0    = 3'd1;
    localparam logic [2:0] CSR_W     = 3'd2;
    localparam logic [2:0] CSR_H     = 3'd3;
    localparam logic [2:0] CSR_COLOR = 3'd4;
    localparam logic [2:0] CSR_CTRL  = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        WRITE    = 3'd2,
        NEXT_ROW = 3'd3,
        DONE_ST  = 3'd4
    } fill_state_t;

    // VRAM word address of the first word of a scanline.
    function automatic logic [14:0] row_base(input logic [8:0] row);
        return 15'(row) * 15'(WORDS_PER_ROW);
    endfunction

endpackage

// File: rtl/fill_word_mask.sv
// Byte-enable generator: marks which 4-pixel groups of one VRAM word
// fall inside the horizontal span [x0, xe). Group g drives enable bit 3-g.
module fill_word_mask
    import vga_fb_pkg::*;
(
    input  logic [5:0]  i_word,
    input  logic [9:0]  i_x0,
    input  logic [10:0] i_xe,
    output logic [3:0]  o_be
);

    logic [10:0] w_grp_lo;
    logic [10:0] w_grp_hi;

    // Test each group's pixel range against the span; x0 and xe are 4-px aligned.
    always_comb begin
        o_be     = '0;
        w_grp_lo = '0;
        w_grp_hi = '0;
        for (int g = 0; g < GROUPS_PER_WD; g++) begin
            w_grp_lo = {1'b0, i_word, 2'(g), 2'b00};
            w_grp_hi = w_grp_lo + 11'(PX_PER_GROUP);
            o_be[3 - g] = (w_grp_lo >= {1'b0, i_x0}) && (w_grp_hi <= i_xe);
        end
    end

endmodule

// File: rtl/vga_rect_fill_engine.sv
// Rectangle fill engine: Avalon-MM CSR slave holding a rectangle and a
// 2-bit colour, and an Avalon-MM master that writes packed 2bpp words
// (16 px per word) into VGA VRAM, one word per cycle within a row.
//
// Master handshake: a word is transferred on a rising edge where
// AVM_WRITE=1 and AVM_WAITREQUEST=0; while AVM_WAITREQUEST=1 the address,
// byte enables and data are held unchanged until that edge.
module vga_rect_fill_engine
    import vga_fb_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AVL_READ,
    input  logic        AVL_WRITE,
    input  logic        AVL_CS,
    input  logic [2:0]  AVL_ADDR,
    input  logic [31:0] AVL_WRITEDATA,
    output logic [31:0] AVL_READDATA,
    output logic [14:0] AVM_ADDR,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST,
    output logic        IRQ,
    output logic [2:0]  o_dbg_state
);

    fill_state_t r_state;

    logic [9:0]  r_x0;
    logic [8:0]  r_y0;
    logic [10:0] r_w;
    logic [9:0]  r_h;
    logic [1:0]  r_color;
    logic        r_irq_en;
    logic        r_done;
    logic        r_err;
    logic [10:0] r_xe;
    logic [9:0]  r_ye;
    logic [8:0]  r_row;
    logic [5:0]  r_word;

    logic        w_busy;
    logic        w_csr_wr;
    logic        w_cfg_wr;
    logic        w_ctrl_wr;
    logic        w_start;
    logic [11:0] w_x_end_raw;
    logic [10:0] w_y_end_raw;
    logic [10:0] w_xe;
    logic [9:0]  w_ye;
    logic        w_oob;
    logic [10:0] w_xe_m1;
    logic [5:0]  w_last_word;
    logic [9:0]  w_row_next;
    logic        w_writing;
    logic [3:0]  w_be;
    logic        w_unused;

    assign w_busy    = (r_state != IDLE);
    assign w_csr_wr  = AVL_CS && AVL_WRITE;
    assign w_cfg_wr  = w_csr_wr && !w_busy;
    assign w_ctrl_wr = w_csr_wr && (AVL_ADDR == CSR_CTRL);
    assign w_start   = w_ctrl_wr && AVL_WRITEDATA[0] && !w_busy;

    // Clipping arithmetic; widths are wide enough that the raw sums never wrap.
    assign w_x_end_raw = {2'b00, r_x0} + {1'b0, r_w};
    assign w_y_end_raw = {2'b00, r_y0} + {1'b0, r_h};
    assign w_xe  = (w_x_end_raw > 12'(FB_WIDTH))  ? 11'(FB_WIDTH)  : w_x_end_raw[10:0];
    assign w_ye  = (w_y_end_raw > 11'(FB_HEIGHT)) ? 10'(FB_HEIGHT) : w_y_end_raw[9:0];
    assign w_oob = (r_x0 >= 10'(FB_WIDTH)) || (r_y0 >= 9'(FB_HEIGHT));

    // Last word touched in a row; xe never exceeds FB_WIDTH so bit 10 is zero.
    assign w_xe_m1     = r_xe - 11'd1;
    assign w_last_word = w_xe_m1[9:4];
    assign w_row_next  = {1'b0, r_row} + 10'd1;

    assign w_unused = &{1'b0, AVL_WRITEDATA[31:11], w_xe_m1[10], w_xe_m1[3:0]};

    fill_word_mask u_mask (
        .i_word (r_word),
        .i_x0   (r_x0),
        .i_xe   (r_xe),
        .o_be   (w_be)
    );

    // Rectangle/colour registers are frozen while a fill runs; IRQ_EN is always writable.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_color  <= '0;
            r_irq_en <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                case (AVL_ADDR)
                    CSR_X0:    r_x0    <= {AVL_WRITEDATA[9:2], 2'b00};
                    CSR_Y0:    r_y0    <= AVL_WRITEDATA[8:0];
                    CSR_W:     r_w     <= {AVL_WRITEDATA[10:2], 2'b00};
                    CSR_H:     r_h     <= AVL_WRITEDATA[9:0];
                    CSR_COLOR: r_color <= AVL_WRITEDATA[1:0];
                    default:   ;
                endcase
            end
            if (w_ctrl_wr) begin
                r_irq_en <= AVL_WRITEDATA[8];
            end
        end
    end

    // Fill sequencer plus sticky DONE/ERR; FSM updates after the clear so completion wins.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_xe    <= '0;
            r_ye    <= '0;
            r_row   <= '0;
            r_word  <= '0;
        end else begin
            if (w_ctrl_wr && AVL_WRITEDATA[1]) begin
                r_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_oob) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if ((r_w == '0) || (r_h == '0)) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_xe    <= w_xe;
                        r_ye    <= w_ye;
                        r_row   <= r_y0;
                        r_word  <= r_x0[9:4];
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!AVM_WAITREQUEST) begin
                        if (r_word < w_last_word) begin
                            r_word <= r_word + 6'd1;
                        end else begin
                            r_state <= NEXT_ROW;
                        end
                    end
                end
                NEXT_ROW: begin
                    r_row <= w_row_next[8:0];
                    if (w_row_next == r_ye) begin
                        r_state <= DONE_ST;
                    end else begin
                        r_word  <= r_x0[9:4];
                        r_state <= WRITE;
                    end
                end
                DONE_ST: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Master outputs are pure functions of registered state, so they hold under waitrequest.
    assign w_writing     = (r_state == WRITE);
    assign AVM_WRITE     = w_writing;
    assign AVM_ADDR      = w_writing ? (row_base(r_row) + {9'b0, r_word}) : '0;
    assign AVM_BYTE_EN   = w_writing ? w_be : '0;
    assign AVM_WRITEDATA = w_writing ? {16{r_color}} : '0;

    assign IRQ         = r_done && r_irq_en;
    assign o_dbg_state = r_state;

    // Zero-latency CSR read mux; offsets 6 and 7 read as zero.
    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            case (AVL_ADDR)
                CSR_X0:    AVL_READDATA = {22'b0, r_x0};
                CSR_Y0:    AVL_READDATA = {23'b0, r_y0};
                CSR_W:     AVL_READDATA = {21'b0, r_w};
                CSR_H:     AVL_READDATA = {22'b0, r_h};
                CSR_COLOR: AVL_READDATA = {30'b0, r_color};
                CSR_CTRL:  AVL_READDATA = {23'b0, r_irq_en, 5'b0, r_err, r_done, w_busy};
                default:   AVL_READDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_engine.sv
// Bench for the rectangle fill engine: directed cases plus randomized
// rectangles, checked against a pixel-level reference model.
module tb_vga_rect_fill_engine;
    import vga_fb_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        AVL_READ = 1'b0;
    logic        AVL_WRITE = 1'b0;
    logic        AVL_CS = 1'b0;
    logic [2:0]  AVL_ADDR = '0;
    logic [31:0] AVL_WRITEDATA = '0;
    logic [31:0] AVL_READDATA;
    logic [14:0] AVM_ADDR;
    logic        AVM_WRITE;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQUEST = 1'b0;
    logic        IRQ;
    logic [2:0]  dbg_state;

    vga_rect_fill_engine dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .AVL_READ        (AVL_READ),
        .AVL_WRITE       (AVL_WRITE),
        .AVL_CS          (AVL_CS),
        .AVL_ADDR        (AVL_ADDR),
        .AVL_WRITEDATA   (AVL_WRITEDATA),
        .AVL_READDATA    (AVL_READDATA),
        .AVM_ADDR        (AVM_ADDR),
        .AVM_WRITE       (AVM_WRITE),
        .AVM_BYTE_EN     (AVM_BYTE_EN),
        .AVM_WRITEDATA   (AVM_WRITEDATA),
        .AVM_WAITREQUEST (AVM_WAITREQUEST),
        .IRQ             (IRQ),
        .o_dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [50:0] exp_q[$];   // {addr[14:0], be[3:0], data[31:0]}
    int acc_cyc[$];
    int n_acc = 0;
    int first_wr_cyc = -1;
    int start_cyc = 0;
    int wait_mode = 0;       // 0 none, 1 random, 2 stall second word
    int stall_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = a; AVL_WRITEDATA = d;
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = a;
        #1;
        d = AVL_READDATA;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    // Reference model: paint pixels of the clipped rectangle, then emit
    // one expected write per touched word, row by row, left to right.
    task automatic model(input logic [31:0] dx0, input logic [31:0] dy0,
                         input logic [31:0] dw, input logic [31:0] dh,
                         input logic [31:0] dcol, output logic e_err);
        int x0, y0, w, h, xe, ye;
        logic [3:0] be[WORDS_PER_ROW];
        logic [31:0] fill;
        x0 = int'(dx0[9:0]) & ~3;
        y0 = int'(dy0[8:0]);
        w  = int'(dw[10:0]) & ~3;
        h  = int'(dh[9:0]);
        fill = {16{dcol[1:0]}};
        e_err = (x0 >= FB_WIDTH) || (y0 >= FB_HEIGHT);
        if (e_err || w == 0 || h == 0) return;
        xe = (x0 + w > FB_WIDTH)  ? FB_WIDTH  : x0 + w;
        ye = (y0 + h > FB_HEIGHT) ? FB_HEIGHT : y0 + h;
        for (int y = y0; y < ye; y++) begin
            for (int k = 0; k < WORDS_PER_ROW; k++) be[k] = 4'b0;
            for (int px = x0; px < xe; px++) be[px / 16][3 - (px % 16) / 4] = 1'b1;
            for (int k = 0; k < WORDS_PER_ROW; k++)
                if (be[k] != 4'b0) exp_q.push_back({15'(y * WORDS_PER_ROW + k), be[k], fill});
        end
    endtask

    // Monitor: picks waitrequest for the next edge, checks held outputs
    // under a stall, and scores every accepted word.
    task automatic mon();
        logic hold_chk;
        logic [14:0] h_addr;
        logic [3:0]  h_be;
        logic [31:0] h_data;
        logic ws;
        logic [50:0] e;
        hold_chk = 1'b0;
        forever begin
            @(negedge CLK);
            if (hold_chk) begin
                chk("hold_write", 32'(AVM_WRITE), 32'd1);
                chk("hold_addr", 32'(AVM_ADDR), 32'(h_addr));
                chk("hold_be", 32'(AVM_BYTE_EN), 32'(h_be));
                chk("hold_data", AVM_WRITEDATA, h_data);
                hold_chk = 1'b0;
            end
            if (AVM_WRITE) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                ws = 1'b0;
                if (wait_mode == 1) ws = ($urandom_range(0, 3) == 0);
                if (wait_mode == 2 && n_acc == 1 && stall_left > 0) begin
                    ws = 1'b1;
                    stall_left--;
                end
                AVM_WAITREQUEST = ws;
                if (ws) begin
                    hold_chk = 1'b1;
                    h_addr = AVM_ADDR; h_be = AVM_BYTE_EN; h_data = AVM_WRITEDATA;
                end else begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(AVM_ADDR), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(AVM_ADDR), 32'(e[50:36]));
                        chk("wr_be", 32'(AVM_BYTE_EN), 32'(e[35:32]));
                        chk("wr_data", AVM_WRITEDATA, e[31:0]);
                        chk("wr_below_palette", 32'(AVM_ADDR < PALETTE_BASE), 32'd1);
                    end
                    n_acc++;
                    acc_cyc.push_back(cyc);
                end
            end else begin
                AVM_WAITREQUEST = 1'b0;
            end
        end
    endtask

    // Program, start and wait for one fill, then score its completion.
    task automatic run_job(input string name, input logic [31:0] x0, input logic [31:0] y0,
                           input logic [31:0] w, input logic [31:0] h, input logic [31:0] col,
                           input logic irq_en, input int mode, input logic poke);
        logic e_err;
        logic [31:0] st;
        logic [31:0] rd;
        int n_exp;
        int timed_out;
        csr_wr(CSR_X0, x0);
        csr_wr(CSR_Y0, y0);
        csr_wr(CSR_W, w);
        csr_wr(CSR_H, h);
        csr_wr(CSR_COLOR, col);
        model(x0, y0, w, h, col, e_err);
        n_exp = exp_q.size();
        n_acc = 0;
        acc_cyc.delete();
        first_wr_cyc = -1;
        wait_mode = mode;
        stall_left = 3;
        @(negedge CLK);
        start_cyc = cyc;
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = CSR_CTRL;
        AVL_WRITEDATA = {23'b0, irq_en, 7'b0, 1'b1};
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
        if (poke) begin
            csr_wr(CSR_X0, 32'h3FC);
            csr_wr(CSR_CTRL, {23'b0, irq_en, 7'b0, 1'b1});
            csr_rd(CSR_X0, rd);
            chk({name, "_x0_frozen"}, rd, x0 & 32'h3FC);
        end
        timed_out = 1;
        for (int i = 0; i < 3000; i++) begin
            csr_rd(CSR_CTRL, st);
            if (!st[0]) begin
                timed_out = 0;
                break;
            end
        end
        chk({name, "_timeout"}, 32'(timed_out), 32'd0);
        chk({name, "_status"}, st, {23'b0, irq_en, 5'b0, e_err, 1'b1, 1'b0});
        chk({name, "_nwrites"}, 32'(n_acc), 32'(n_exp));
        chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_irq"}, 32'(IRQ), 32'(irq_en));
        if (n_exp > 0) chk({name, "_first_lat"}, 32'(first_wr_cyc - start_cyc), 32'd2);
        exp_q.delete();
        wait_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] rd;
    logic [2:0]  mask_addr[6] = '{CSR_X0, CSR_Y0, CSR_W, CSR_H, CSR_COLOR, 3'd6};
    logic [31:0] mask_exp[6]  = '{32'h3FC, 32'h1FF, 32'h7FC, 32'h3FF, 32'h3, 32'h0};
    int found;

    initial begin
        fork
            mon();
        join_none

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_avm_write", 32'(AVM_WRITE), 32'd0);
        chk("rst_avm_addr", 32'(AVM_ADDR), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_dbg_state", 32'(dbg_state), 32'(IDLE));
        @(negedge CLK);
        RESET = 1'b1;
        for (int a = 0; a < 8; a++) begin
            csr_rd(3'(a), rd);
            chk("rst_csr", rd, 32'd0);
        end

        // CSR field masking
        for (int i = 0; i < 6; i++) csr_wr(mask_addr[i], 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            csr_rd(mask_addr[i], rd);
            chk("csr_mask", rd, mask_exp[i]);
        end

        // Directed cases
        run_job("t1_full_word", 0, 0, 16, 1, 2, 1'b0, 0, 1'b0);
        run_job("t2_mid_word", 4, 2, 8, 1, 3, 1'b0, 0, 1'b0);
        run_job("t3_three_words", 12, 1, 24, 1, 1, 1'b0, 0, 1'b0);
        chk("t3_count", 32'(acc_cyc.size()), 32'd3);
        chk("t3_back_to_back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        run_job("t4_clipped", 632, 478, 32, 8, 2, 1'b0, 0, 1'b0);
        chk("t4_row_bubble", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        run_job("t5_stall", 12, 1, 24, 1, 1, 1'b1, 2, 1'b1);
        csr_wr(CSR_CTRL, 32'h102);
        chk("t5_irq_cleared", 32'(IRQ), 32'd0);
        csr_rd(CSR_CTRL, rd);
        chk("t5_done_cleared", rd, 32'h100);
        run_job("t6_x_oob", 640, 0, 16, 1, 1, 1'b0, 0, 1'b0);
        run_job("zero_w", 0, 0, 3, 5, 1, 1'b0, 0, 1'b0);

        // Randomized rectangles with random stalls
        for (int n = 0; n < 25; n++) begin
            run_job("rnd", $urandom_range(0, 1023), $urandom_range(0, 511),
                    $urandom_range(0, 2047), $urandom_range(0, 6),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1, 1'b0);
        end

        // Reset in the middle of a 4-row fill
        csr_wr(CSR_X0, 0);
        csr_wr(CSR_Y0, 10);
        csr_wr(CSR_W, 32);
        csr_wr(CSR_H, 4);
        csr_wr(CSR_COLOR, 1);
        begin
            logic e_err;
            model(0, 10, 32, 4, 1, e_err);
        end
        n_acc = 0;
        wait_mode = 0;
        csr_wr(CSR_CTRL, 32'h1);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            #1;
            if (n_acc >= 2) begin
                found = 1;
                break;
            end
        end
        chk("abort_two_writes", 32'(found), 32'd1);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("abort_write", 32'(AVM_WRITE), 32'd0);
        chk("abort_addr", 32'(AVM_ADDR), 32'd0);
        chk("abort_be", 32'(AVM_BYTE_EN), 32'd0);
        chk("abort_data", AVM_WRITEDATA, 32'd0);
        exp_q.delete();
        csr_rd(CSR_CTRL, rd);
        chk("abort_status", rd, 32'd0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        repeat (20) @(negedge CLK);
        chk("abort_no_more_writes", 32'(n_acc), 32'd2);
        csr_rd(CSR_CTRL, rd);
        chk("abort_idle_status", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill_engine.md
Name: vga_rect_fill_engine

Overview:
Hardware rectangle-fill engine that sits directly upstream of the VGA pixel interface.
- Takes a rectangle and a 2-bit palette index through a small Avalon-MM slave CSR bank.
- Acting as an Avalon-MM master, writes 32-bit words (16 px × 2 bpp) into the VGA VRAM slave.
- Used by software to clear screen regions and draw UI blocks without CPU per-word writes.

Parameters:
FB_WIDTH, 640, framebuffer width in pixels
FB_HEIGHT, 480, framebuffer height in pixels
WORDS_PER_ROW, 40, VRAM words per scanline (FB_WIDTH/16)

Ports:
CLK  in  1  system clock, 50 MHz, shared with VRAM write port
RESET  in  1  asynchronous, active-low reset
AVL_READ  in  1  CSR slave read
AVL_WRITE  in  1  CSR slave write
AVL_CS  in  1  CSR slave chip select
AVL_ADDR  in  3  CSR word offset
AVL_WRITEDATA  in  32  CSR write data
AVL_READDATA  out  32  CSR read data, zero-latency (combinational)
AVM_ADDR  out  15  VRAM word address
AVM_WRITE  out  1  master write request
AVM_BYTE_EN  out  4  byte enables
AVM_WRITEDATA  out  32  fill data
AVM_WAITREQUEST  in  1  slave stall
IRQ  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- CSR map:
  - 0 X0[9:0]; bits [1:0] forced 0 (4-px granularity)
  - 1 Y0[8:0]
  - 2 W[10:0]; bits [1:0] forced 0
  - 3 H[9:0]
  - 4 COLOR[1:0]
  - 5 CTRL/STATUS: write bit0=START, bit1=clear DONE, bit8=IRQ_EN; read bit0=BUSY, bit1=DONE (sticky), bit2=ERR (sticky), bit8=IRQ_EN
  - 6–7 read 0
- Reset: all CSRs 0; outputs 0; state IDLE.
- CSR writes to offsets 0–4 while BUSY are ignored. START while BUSY is ignored. START clears DONE and ERR.
- Pixel packing: pixel p in a word occupies bits [31−2p:30−2p]. Byte enable bit (3−g) covers pixel group g (pixels 4g..4g+3). Fill data = COLOR replicated 16×.
- FSM:
  - IDLE: on START → SETUP.
  - SETUP (1 cycle):
    - If X0 ≥ FB_WIDTH or Y0 ≥ FB_HEIGHT → ERR=1, DONE=1, IDLE, no writes.
    - Otherwise clip: xe = min(X0+W, FB_WIDTH), ye = min(Y0+H, FB_HEIGHT).
    - If W==0 or H==0 → DONE=1, IDLE.
    - Otherwise set row=Y0, word=X0[9:4] → WRITE.
  - WRITE: AVM_WRITE=1, AVM_ADDR = row*WORDS_PER_ROW + word, BYTE_EN = groups of [X0,xe) inside this word.
    - While AVM_WAITREQUEST=1, hold all master outputs stable.
    - When accepted: if word < (xe−1)>>4, word++; else → NEXT_ROW.
  - NEXT_ROW (1 cycle, AVM_WRITE=0): row++; if row == ye → DONE_ST, else word=X0[9:4] → WRITE.
  - DONE_ST: DONE=1 → IDLE.
- Latency: first AVM_WRITE asserted 2 cycles after START write. Throughput is 1 word/cycle within a row, with 1 bubble per row.
- Total writes = (ye−Y0) × ((xe−1)>>4 − X0[9:4] + 1).
- AVM_ADDR never exceeds 19199, so the palette region (≥0x4B00) is never touched.
- Reset mid-fill: immediate abort; partial rectangle stays in VRAM; BUSY=0, DONE=0.

Decomposition:
- Package vga_fb_pkg:
  - FB_WIDTH, FB_HEIGHT, WORDS_PER_ROW, PALETTE_BASE=15'h4B00
  - CSR offset constants
  - fill_state_t enum {IDLE, SETUP, WRITE, NEXT_ROW, DONE_ST}
- Sub-module fill_word_mask (combinational): inputs word index, X0, xe; output 4-bit byte enable.

Test Plan:
1. X0=0, Y0=0, W=16, H=1, COLOR=2, START → one write: ADDR 0, DATA 0xAAAAAAAA, BE 4'b1111; DONE=1, BUSY=0.
2. X0=4, Y0=2, W=8, H=1, COLOR=3 → one write: ADDR 80, DATA 0xFFFFFFFF, BE 4'b0110.
3. X0=12, Y0=1, W=24, H=1, COLOR=1 → writes ADDR 40/41/42 with BE 0001/1111/1000 on consecutive cycles, DATA 0x55555555.
4. X0=632, Y0=478, W=32, H=8 → clipped; two writes: ADDR 19159 and 19199, BE 4'b0011 each; ERR=0.
5. Case 3 with AVM_WAITREQUEST high for 3 cycles on the second word → master outputs held constant; same 3 writes total; IRQ high after DONE when IRQ_EN=1.
6. X0=640 START → ERR=1, DONE=1, zero writes. Then a 4-row fill with RESET asserted after 2 writes → all outputs 0 immediately, BUSY=0, no further writes.
